// File: rtl/instr_enc.sv
// instr_enc: MIPS-subset instruction encoder feeding a 64-word instruction memory through a valid/ready write port.
// Build option: define INSTR_ENC_ILLEGAL_TRAP_EN to trap (not write) mnemonics 10-15 and raise sticky err.
module instr_enc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] addr26,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [6:0]  count,
  output logic        full,
  output logic        err
);
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FULL} state_t;
  state_t      state, state_n;
  logic [5:0]  next_addr;
  logic [31:0] enc;
  logic        acc, done, load;
  always_comb begin
    enc = '0;
    case (mnem)
      4'd0: enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      4'd1: enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      4'd2: enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
      4'd3: enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
      4'd4: enc = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
      4'd5: enc = {6'b100011, rs, rt, imm};
      4'd6: enc = {6'b101011, rs, rt, imm};
      4'd7: enc = {6'b000100, rs, rt, imm};
      4'd8: enc = {6'b001000, rs, rt, imm};
      4'd9: enc = {6'b000010, addr26};
      default: enc = '0;
    endcase
  end
  assign wr_en    = state == ST_PEND;
  assign full     = count == 7'd64;
  assign in_ready = state == ST_IDLE || (state == ST_PEND && wr_ready && count < 7'd63);
  assign acc      = in_valid && in_ready;
  assign done     = wr_en && wr_ready;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic illegal, err_q;
  assign illegal = mnem > 4'd9;
  assign load    = acc && !illegal;
  assign err     = err_q;
  always_ff @(posedge clk)
    if (reset || clear) err_q <= 1'b0;
    else if (acc && illegal) err_q <= 1'b1;
`else
  assign load = acc;
  assign err  = 1'b0;
`endif
  // a completion and a new accept in the same cycle keep the pipe in PEND
  always_comb
    state_n = load ? ST_PEND : done ? (count == 7'd63 ? ST_FULL : ST_IDLE) : state;
  always_ff @(posedge clk)
    if (reset || clear) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      wr_addr   <= '0;
      wr_data   <= '0;
      count     <= '0;
      next_addr <= '0;
    end else if (clear) begin
      count     <= '0;
      next_addr <= '0;
    end else begin
      if (done) begin
        count     <= count + 7'd1;
        next_addr <= next_addr + 6'd1;
      end
      if (load) begin
        wr_data <= enc;
        wr_addr <= next_addr + {5'd0, done};
      end
    end
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: directed vector table, corner sequences and a randomized scoreboard run for instr_enc.
module tb_instr_enc;
  logic        clk = 0, reset, clear, in_valid, in_ready, wr_en, wr_ready, full, err;
  logic [3:0]  mnem;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] addr26;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  count;
  int n_chk = 0, n_fail = 0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  instr_enc dut (.clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .addr26(addr26), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .full(full), .err(err));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] m; logic [4:0] s, t, d; logic [15:0] i; logic [25:0] a; logic [31:0] exp;
  } vec_t;
  typedef struct { logic [31:0] d; logic [5:0] a; } wr_t;
  vec_t vecs[12];
  wr_t  exp_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic req(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic [15:0] i, input logic [25:0] a);
    in_valid = 1; mnem = m; rs = s; rt = t; rd = d; imm = i; addr26 = a;
  endtask
  task automatic do_clear();
    @(negedge clk); clear = 1; in_valid = 0; wr_ready = 0;
    @(negedge clk); clear = 0;
  endtask
  function automatic logic [31:0] enc_ref(int m, int s, int t, int d, int im, int a);
    int funct[5] = '{32, 34, 36, 37, 42};
    int op[4]    = '{35, 43, 4, 8};
    if (m < 5) return (s << 21) | (t << 16) | (d << 11) | funct[m];
    if (m < 9) return (op[m-5] << 26) | (s << 21) | (t << 16) | im;
    if (m == 9) return (2 << 26) | a;
    return 0;
  endfunction
  initial begin
    int done_cnt;
    bit exp_err, exp_rdy;
    vecs[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0, 32'h00221820};
    vecs[1]  = '{4'd5, 5'd0,  5'd8,  5'd0,  16'h0004, 26'h0, 32'h8C080004};
    vecs[2]  = '{4'd7, 5'd8,  5'd0,  5'd0,  16'hFFFF, 26'h0, 32'h1100FFFF};
    vecs[3]  = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010};
    vecs[4]  = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h0000, 26'h0, 32'h00853022};
    vecs[5]  = '{4'd2, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0, 32'h03FFF824};
    vecs[6]  = '{4'd3, 5'd0,  5'd0,  5'd1,  16'h0000, 26'h0, 32'h00000825};
    vecs[7]  = '{4'd4, 5'd2,  5'd3,  5'd4,  16'h0000, 26'h0, 32'h0043202A};
    vecs[8]  = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0010, 26'h0, 32'hAFBF0010};
    vecs[9]  = '{4'd8, 5'd0,  5'd1,  5'd0,  16'h7FFF, 26'h0, 32'h20017FFF};
    vecs[10] = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
    vecs[11] = '{4'd0, 5'd31, 5'd0,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03E0F820};
    reset = 1; clear = 0; in_valid = 0; wr_ready = 0;
    req(0, 0, 0, 0, 0, 0); in_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0; #1;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", {25'd0, count}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    // back-to-back table at one instruction per cycle
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) req(vecs[i].m, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].i, vecs[i].a);
      else in_valid = 0;
      wr_ready = 1; #1;
      chk("tbl_in_ready", {31'd0, in_ready}, 1);
      if (i > 0) begin
        chk("tbl_wr_en", {31'd0, wr_en}, 1);
        chk("tbl_wr_addr", {26'd0, wr_addr}, i - 1);
        chk("tbl_wr_data", wr_data, vecs[i-1].exp);
        chk("tbl_count", {25'd0, count}, i - 1);
      end
    end
    @(negedge clk); #1;
    chk("tbl_final_count", {25'd0, count}, 12);
    chk("tbl_final_wr_en", {31'd0, wr_en}, 0);
    // stalled jump holds everything
    do_clear();
    req(9, 0, 0, 0, 0, 26'h0000010); wr_ready = 0; #1;
    chk("j_in_ready", {31'd0, in_ready}, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("j_hold_wr_en", {31'd0, wr_en}, 1);
      chk("j_hold_wr_data", wr_data, 32'h08000010);
      chk("j_hold_wr_addr", {26'd0, wr_addr}, 0);
      chk("j_hold_in_ready", {31'd0, in_ready}, 0);
      chk("j_hold_count", {25'd0, count}, 0);
    end
    @(negedge clk); in_valid = 0; wr_ready = 1;
    @(negedge clk); wr_ready = 0; #1;
    chk("j_done_count", {25'd0, count}, 1);
    chk("j_done_wr_en", {31'd0, wr_en}, 0);
    // fill all 64 words
    do_clear();
    req(8, 1, 2, 0, 16'h0001, 0); wr_ready = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (full) break;
    end
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_count", {25'd0, count}, 64);
    chk("fill_in_ready", {31'd0, in_ready}, 0);
    chk("fill_wr_en", {31'd0, wr_en}, 0);
    @(negedge clk); #1;
    chk("fill_stay_count", {25'd0, count}, 64);
    chk("fill_stay_in_ready", {31'd0, in_ready}, 0);
    do_clear(); #1;
    chk("fill_clr_count", {25'd0, count}, 0);
    chk("fill_clr_in_ready", {31'd0, in_ready}, 1);
    chk("fill_clr_full", {31'd0, full}, 0);
    req(0, 1, 2, 3, 0, 0);
    @(negedge clk); in_valid = 0; #1;
    chk("fill_clr_addr", {26'd0, wr_addr}, 0);
    chk("fill_clr_wr_en", {31'd0, wr_en}, 1);
    // illegal mnemonic
    do_clear();
    req(12, 1, 2, 3, 16'h1234, 26'h155); wr_ready = 1; #1;
    chk("ill_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk); in_valid = 0; #1;
    chk("ill_wr_en", {31'd0, wr_en}, TRAP ? 0 : 1);
    chk("ill_err", {31'd0, err}, TRAP ? 1 : 0);
    if (!TRAP) chk("ill_wr_data", wr_data, 0);
    @(negedge clk); #1;
    chk("ill_count", {25'd0, count}, TRAP ? 0 : 1);
    chk("ill_err_hold", {31'd0, err}, TRAP ? 1 : 0);
    do_clear(); #1;
    chk("ill_clr_err", {31'd0, err}, 0);
    // reset mid-PEND beats clear and a simultaneous handshake
    req(0, 1, 2, 3, 0, 0); wr_ready = 1;
    @(negedge clk); req(1, 4, 5, 6, 0, 0);
    @(negedge clk); in_valid = 0; wr_ready = 0; #1;
    chk("rp_pend", {31'd0, wr_en}, 1);
    chk("rp_addr", {26'd0, wr_addr}, 1);
    @(negedge clk); reset = 1; clear = 1; req(2, 7, 7, 7, 0, 0); wr_ready = 1;
    @(negedge clk); reset = 0; clear = 0; in_valid = 0; wr_ready = 0; #1;
    chk("rp_wr_en", {31'd0, wr_en}, 0);
    chk("rp_count", {25'd0, count}, 0);
    chk("rp_err", {31'd0, err}, 0);
    chk("rp_wr_data", wr_data, 0);
    chk("rp_in_ready", {31'd0, in_ready}, 1);
    req(5, 0, 8, 0, 16'h0004, 0);
    @(negedge clk); in_valid = 0; #1;
    chk("rp_next_addr", {26'd0, wr_addr}, 0);
    chk("rp_next_data", wr_data, 32'h8C080004);
    // randomized run against the scoreboard model
    do_clear();
    exp_q.delete(); done_cnt = 0; exp_err = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      clear = $urandom_range(0, 399) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      mnem = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); addr26 = 26'($urandom);
      wr_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_rdy = done_cnt < 64 && (exp_q.size() == 0 || (wr_ready && done_cnt < 63));
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("rnd_wr_en", {31'd0, wr_en}, exp_q.size() != 0);
      chk("rnd_count", {25'd0, count}, done_cnt);
      chk("rnd_full", {31'd0, full}, done_cnt == 64);
      chk("rnd_err", {31'd0, err}, {31'd0, exp_err});
      if (exp_q.size() != 0) begin
        chk("rnd_wr_data", wr_data, exp_q[0].d);
        chk("rnd_wr_addr", {26'd0, wr_addr}, {26'd0, exp_q[0].a});
      end
      if (clear) begin
        exp_q.delete(); done_cnt = 0; exp_err = 0;
      end else begin
        if (exp_q.size() != 0 && wr_ready) begin
          void'(exp_q.pop_front());
          done_cnt++;
        end
        if (in_valid && exp_rdy) begin
          if (TRAP && mnem > 9) exp_err = 1;
          else exp_q.push_back('{enc_ref(mnem, rs, rt, rd, imm, addr26), 6'((done_cnt + exp_q.size()) % 64)});
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 The block SHALL have the following ports; the clock and reset are listed first.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous restart of address, count and error.
- in_valid  input  1  encode request present.
- in_ready  output  1  request accepted this cycle when in_valid is also high.
- mnem  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 illegal.
- rs, rt, rd  input  5 each  register fields.
- imm  input  16  immediate or branch offset.
- addr26  input  26  jump target field.
- wr_en  output  1  instruction-memory write valid.
- wr_ready  input  1  memory accepts the write this cycle.
- wr_addr  output  6  word address of 64-word instruction memory.
- wr_data  output  32  encoded instruction.
- count  output  7  number of completed writes (0-64).
- full  output  1  count equals 64.
- err  output  1  sticky illegal-mnemonic flag.

Function
REQ-002 Encoding for R-type (mnem 0-4): bits[31:26] 000000, bits[25:21] rs, bits[20:16] rt, bits[15:11] rd, bits[10:6] 0, funct bits[5:0] = 100000, 100010, 100100, 100101, 101010 respectively.
REQ-003 Encoding for I-type: op LW 100011, SW 101011, BEQ 000100, ADDI 001000; fields are op, rs, rt, imm[15:0].
REQ-004 Encoding for J: op 000010 in bits[31:26], addr26 in bits[25:0].
REQ-005 The FSM SHALL have three states:
- IDLE: no pending write.
- PEND: wr_en high; wr_data and wr_addr are held stable until wr_ready.
- FULL: count is 64.
REQ-006 in_ready = (state==IDLE) or (state==PEND and wr_ready and count<63); it SHALL be 0 in FULL.
REQ-007 An accept (in_valid and in_ready) SHALL register the encoded word into wr_data and wr_addr = next_addr, with wr_en high on the following cycle; latency is 1 cycle.
REQ-008 A write completes when wr_en and wr_ready are both high: count+1 and next_addr+1 (mod 64).
REQ-009 When a write completes in the same cycle as an accept, the block SHALL stay in PEND with the new word, sustaining 1 instruction/cycle.
REQ-010 When the completion takes count to 64, the block SHALL enter FULL; next_addr wraps to 0; wr_en drops.
REQ-011 While wr_en is high and wr_ready is low, all outputs SHALL be held unchanged.
REQ-012 clear SHALL return the block to IDLE with count=0, next_addr=0, err=0 and wr_en=0.
REQ-013 clear SHALL win over a simultaneous accept or completion; an in-flight word is dropped and not counted.
REQ-014 full SHALL equal (count==64) combinationally from registered count.

Reset
REQ-015 reset high SHALL force, on the next edge: state IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, err=0, in_ready=1 from the following cycle.
REQ-016 reset mid-PEND SHALL abandon the pending write; reset has priority over clear and all other inputs.

Configuration
REQ-017 Macro INSTR_ENC_ILLEGAL_TRAP_EN controls handling of illegal mnemonics (10-15).
- Defined: an illegal mnemonic is accepted, not written, and count/address are not advanced; err is set and held until reset or clear.
- Undefined: an illegal mnemonic encodes to 32'h00000000 and is written as a normal instruction; err is tied to 0.

Verification
REQ-018 ADD rs=1 rt=2 rd=3 with wr_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=32'h00221820; count=1 one cycle later.
REQ-019 Back-to-back LW rs=0 rt=8 imm=4, then BEQ rs=8 rt=0 imm=16'hFFFF, with wr_ready=1 -> wr_data=32'h8C080004 @0, then 32'h1100FFFF @1; in_ready stays high.
REQ-020 J addr26=26'h0000010 accepted, wr_ready held 0 for 3 cycles -> wr_data=32'h08000010 stable, in_ready=0, count unchanged until wr_ready=1.
REQ-021 64 consecutive ADDI writes -> full=1, count=64, in_ready=0, wr_en=0, internal next_addr=0; clear -> count=0, in_ready=1.
REQ-022 mnem=12 with INSTR_ENC_ILLEGAL_TRAP_EN defined -> no wr_en, err=1, count unchanged; without the macro -> wr_data=0 written, err=0.
REQ-023 reset asserted while in PEND -> next cycle wr_en=0, count=0, err=0; next accept writes to address 0.
